// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic unit with an accumulator and a STAGES-deep valid-tracked output pipe.
// Optional registered Zero flag, enabled by defining LOGIC_ZERO_FLAG_EN.
module logic_unit_pipe #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 1
) (
    input  logic             CLK,
    input  logic             Clr,
    input  logic             CE,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       Op,
    input  logic             Acc,
    input  logic             In_valid,
    output logic [WIDTH-1:0] Q,
    output logic             Out_valid
`ifdef LOGIC_ZERO_FLAG_EN
   ,output logic             Zero
`endif
);

    typedef enum logic [2:0] {
        OpAnd  = 3'b000,
        OpOr   = 3'b001,
        OpXor  = 3'b010,
        OpNand = 3'b011,
        OpNor  = 3'b100,
        OpXnor = 3'b101,
        OpPass = 3'b110,
        OpNot  = 3'b111
    } op_e;

    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] operand_x;
    logic [WIDTH-1:0] result;
    logic             accept;

    logic [WIDTH-1:0] data_q [STAGES];
    logic [STAGES-1:0] valid_q;

    assign operand_x = Acc ? acc_q : A;
    assign accept    = CE & In_valid;

    always_comb begin
        result = '0;
        unique case (op_e'(Op))
            OpAnd:  result = operand_x & B;
            OpOr:   result = operand_x | B;
            OpXor:  result = operand_x ^ B;
            OpNand: result = ~(operand_x & B);
            OpNor:  result = ~(operand_x | B);
            OpXnor: result = ~(operand_x ^ B);
            OpPass: result = operand_x;
            OpNot:  result = ~operand_x;
        endcase
    end

    // Accumulator tracks the last accepted result regardless of Acc.
    always_ff @(posedge CLK) begin
        if (Clr) begin
            acc_q <= '0;
        end else if (accept) begin
            acc_q <= result;
        end
    end

    // Stage 0 data only loads on accept; it holds on idle cycles.
    always_ff @(posedge CLK) begin
        if (Clr) begin
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= '0;
            end
            valid_q <= '0;
        end else if (CE) begin
            valid_q[0] <= In_valid;
            if (In_valid) begin
                data_q[0] <= result;
            end
            for (int k = 1; k < STAGES; k++) begin
                data_q[k]  <= data_q[k-1];
                valid_q[k] <= valid_q[k-1];
            end
        end
    end

    assign Q         = data_q[STAGES-1];
    assign Out_valid = valid_q[STAGES-1];

`ifdef LOGIC_ZERO_FLAG_EN
    // Flag travels with its data so it shares Q's latency and stall behaviour.
    logic [STAGES-1:0] zero_q;

    always_ff @(posedge CLK) begin
        if (Clr) begin
            zero_q <= '0;
        end else if (CE) begin
            zero_q[0] <= In_valid && (result == '0);
            for (int k = 1; k < STAGES; k++) begin
                zero_q[k] <= zero_q[k-1];
            end
        end
    end

    assign Zero = zero_q[STAGES-1];
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe: three instances (STAGES=1,2,3) share stimulus and are
// checked every cycle against a log-based model; Zero is checked when LOGIC_ZERO_FLAG_EN is set.
module tb_logic_unit_pipe;

    localparam int unsigned W = 8;

    logic         CLK = 1'b0;
    logic         Clr = 1'b0;
    logic         CE = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [2:0]   Op = '0;
    logic         Acc = 1'b0;
    logic         In_valid = 1'b0;

    logic [W-1:0] q1, q2, q3;
    logic         ov1, ov2, ov3;
    logic         z1, z2, z3;

    int checks = 0;
    int errors = 0;
    bit run = 1'b0;

    always #5 CLK = ~CLK;

    logic_unit_pipe #(.WIDTH(W), .STAGES(1)) u_s1 (
        .CLK(CLK), .Clr(Clr), .CE(CE), .A(A), .B(B), .Op(Op), .Acc(Acc),
        .In_valid(In_valid), .Q(q1), .Out_valid(ov1)
`ifdef LOGIC_ZERO_FLAG_EN
       ,.Zero(z1)
`endif
    );

    logic_unit_pipe #(.WIDTH(W), .STAGES(2)) u_s2 (
        .CLK(CLK), .Clr(Clr), .CE(CE), .A(A), .B(B), .Op(Op), .Acc(Acc),
        .In_valid(In_valid), .Q(q2), .Out_valid(ov2)
`ifdef LOGIC_ZERO_FLAG_EN
       ,.Zero(z2)
`endif
    );

    logic_unit_pipe #(.WIDTH(W), .STAGES(3)) u_s3 (
        .CLK(CLK), .Clr(Clr), .CE(CE), .A(A), .B(B), .Op(Op), .Acc(Acc),
        .In_valid(In_valid), .Q(q3), .Out_valid(ov3)
`ifdef LOGIC_ZERO_FLAG_EN
       ,.Zero(z3)
`endif
    );

`ifndef LOGIC_ZERO_FLAG_EN
    assign z1 = 1'b0;
    assign z2 = 1'b0;
    assign z3 = 1'b0;
`endif

    // Model: log of every enabled edge since the last Clr (was it an accept, and what result).
    int           m_cnt = 0;
    logic [W-1:0] m_acc = '0;
    logic         m_log_v [64];
    logic [W-1:0] m_log_d [64];

    function automatic logic [W-1:0] model_op(input logic [2:0] op, input logic [W-1:0] x,
                                              input logic [W-1:0] b);
        case (op)
            3'd0:    return x & b;
            3'd1:    return x | b;
            3'd2:    return x ^ b;
            3'd3:    return ~(x & b);
            3'd4:    return ~(x | b);
            3'd5:    return ~(x ^ b);
            3'd6:    return x;
            default: return ~x;
        endcase
    endfunction

    always @(posedge CLK) begin
        if (Clr) begin
            m_cnt <= 0;
            m_acc <= '0;
        end else if (CE) begin
            m_log_v[m_cnt % 64] <= In_valid;
            m_log_d[m_cnt % 64] <= model_op(Op, Acc ? m_acc : A, B);
            m_cnt               <= m_cnt + 1;
            if (In_valid) m_acc <= model_op(Op, Acc ? m_acc : A, B);
        end
    end

    // Output of an s-deep pipe is the log entry written s enabled edges ago (counting the latest).
    function automatic logic exp_v(input int s);
        return (m_cnt >= s) && m_log_v[(m_cnt - s) % 64];
    endfunction

    function automatic logic [W-1:0] exp_d(input int s);
        return m_log_d[(m_cnt - s) % 64];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp(input int s, input logic [W-1:0] q, input logic ov, input logic z);
        logic ev;
        ev = exp_v(s);
        chk($sformatf("model_s%0d_out_valid", s), 64'(ov), 64'(ev));
        if (ev) chk($sformatf("model_s%0d_q", s), 64'(q), 64'(exp_d(s)));
`ifdef LOGIC_ZERO_FLAG_EN
        chk($sformatf("model_s%0d_zero", s), 64'(z), 64'(ev && (exp_d(s) == '0)));
`else
        if (z) chk("zero_tie", 64'(z), 64'(0));
`endif
    endtask

    always @(negedge CLK) begin
        if (run) begin
            cmp(1, q1, ov1, z1);
            cmp(2, q2, ov2, z2);
            cmp(3, q3, ov3, z3);
        end
    end

    task automatic drive(input logic clr, input logic ce, input logic iv, input logic acc,
                         input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
        Clr = clr; CE = ce; In_valid = iv; Acc = acc; A = a; B = b; Op = op;
        @(negedge CLK);
    endtask

    logic [W-1:0] t2_exp [6];

    initial begin
        t2_exp = '{8'hA5, 8'hF5, 8'h50, 8'h5A, 8'hAA, 8'h55};

        // Reset state
        drive(1, 0, 0, 0, 8'h00, 8'h00, 3'd0);
        run = 1'b1;
        chk("reset_s1_q", 64'(q1), 64'h0);
        chk("reset_s1_ov", 64'(ov1), 64'h0);
        chk("reset_s3_ov", 64'(ov3), 64'h0);

        // Basic AND / OR
        drive(0, 1, 1, 0, 8'hF0, 8'h3C, 3'd0);
        chk("and_q", 64'(q1), 64'h30);
        chk("and_ov", 64'(ov1), 64'h1);
        drive(0, 1, 1, 0, 8'hF0, 8'h3C, 3'd1);
        chk("or_q", 64'(q1), 64'hFC);

        // All remaining ops back-to-back through the two-stage pipe
        for (int i = 0; i < 6; i++) begin
            drive(0, 1, 1, 0, 8'hAA, 8'h0F, 3'(i + 2));
            if (i > 0) begin
                chk($sformatf("ops_s2_q%0d", i - 1), 64'(q2), 64'(t2_exp[i-1]));
                chk($sformatf("ops_s2_ov%0d", i - 1), 64'(ov2), 64'h1);
            end
        end
        drive(0, 1, 0, 0, 8'h00, 8'h00, 3'd0);
        chk("ops_s2_q5", 64'(q2), 64'h55);

        // Accumulate chain
        drive(0, 1, 1, 0, 8'h01, 8'h00, 3'd1);
        chk("acc_q0", 64'(q1), 64'h01);
        drive(0, 1, 1, 1, 8'hFF, 8'h02, 3'd1);
        chk("acc_q1", 64'(q1), 64'h03);
        drive(0, 1, 1, 1, 8'hFF, 8'h04, 3'd1);
        chk("acc_q2", 64'(q1), 64'h07);
        drive(0, 1, 1, 1, 8'hFF, 8'h08, 3'd1);
        chk("acc_q3", 64'(q1), 64'h0F);

        // Stall: latency counts enabled edges only
        for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 8'h00, 8'h00, 3'd0);
        drive(0, 1, 1, 0, 8'h11, 8'h00, 3'd6);
        chk("stall_e1_ov", 64'(ov3), 64'h0);
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, 0, 8'hEE, 8'h77, 3'd1);
            chk("stall_hold_ov", 64'(ov3), 64'h0);
            chk("stall_s1_q", 64'(q1), 64'h11);
        end
        drive(0, 1, 0, 0, 8'h00, 8'h00, 3'd0);
        chk("stall_e2_ov", 64'(ov3), 64'h0);
        drive(0, 1, 0, 0, 8'h00, 8'h00, 3'd0);
        chk("stall_e3_ov", 64'(ov3), 64'h1);
        chk("stall_e3_q", 64'(q3), 64'h11);

        // Reset mid-flight with CE low
        drive(0, 1, 1, 0, 8'h33, 8'h00, 3'd6);
        drive(0, 1, 1, 0, 8'h44, 8'h00, 3'd6);
        drive(1, 0, 0, 0, 8'h00, 8'h00, 3'd0);
        chk("flush_s3_q", 64'(q3), 64'h0);
        chk("flush_s3_ov", 64'(ov3), 64'h0);
        drive(0, 1, 1, 1, 8'hFF, 8'h5A, 3'd1);
        chk("flush_acc_s1", 64'(q1), 64'h5A);
        drive(0, 1, 0, 0, 8'h00, 8'h00, 3'd0);
        chk("flush_s3_ov_e2", 64'(ov3), 64'h0);
        drive(0, 1, 0, 0, 8'h00, 8'h00, 3'd0);
        chk("flush_s3_q_e3", 64'(q3), 64'h5A);

        // Clr beats a simultaneous accept
        drive(1, 1, 1, 0, 8'hFF, 8'h00, 3'd6);
        chk("clr_wins_ov", 64'(ov1), 64'h0);
        drive(0, 1, 1, 1, 8'hFF, 8'h00, 3'd1);
        chk("clr_wins_acc", 64'(q1), 64'h00);

`ifdef LOGIC_ZERO_FLAG_EN
        drive(0, 1, 1, 0, 8'h0F, 8'hF0, 3'd0);
        chk("zero_q", 64'(q1), 64'h00);
        chk("zero_set", 64'(z1), 64'h1);
        drive(0, 1, 1, 0, 8'h0F, 8'hF0, 3'd1);
        chk("zero_q_ff", 64'(q1), 64'hFF);
        chk("zero_clear", 64'(z1), 64'h0);
        drive(0, 1, 0, 0, 8'h00, 8'h00, 3'd0);
        chk("zero_idle_ov", 64'(ov1), 64'h0);
        chk("zero_idle", 64'(z1), 64'h0);
`endif

        drive(0, 1, 0, 0, 8'h00, 8'h00, 3'd0);
        run = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised registered bitwise logic unit.
- Generalises the single-bit registered AND/OR cell to:
  - WIDTH-bit operands;
  - eight selectable operations;
  - an accumulate mode;
  - a STAGES-deep output pipeline with valid tracking.
- Clock enable stalls the whole block.
- Sits between operand registers and downstream datapath logic in the behavioral-level exercise library.

Parameters:
- WIDTH, 8, operand and result width in bits (1..64).
- STAGES, 1, pipeline depth from accepted input to Q (1..4).

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- Clr  input  1  synchronous active-high reset; clears all state on rising CLK edge; overrides CE.
- CE  input  1  clock enable; 0 = entire block holds state.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- Op  input  3  operation select; see Behaviour.
- Acc  input  1  1 = use internal accumulator in place of A.
- In_valid  input  1  input operands valid this cycle.
- Q  output  WIDTH  registered result at pipeline tail.
- Out_valid  output  1  Q holds a valid result.
- Zero  output  1  only with LOGIC_ZERO_FLAG_EN; see Optional Feature.

Behaviour:
- Reset: Clr=1 at a rising edge forces the following to 0, regardless of CE, In_valid or any other input:
  - Q, Out_valid, all pipeline data and valid registers;
  - accumulator acc (WIDTH bits);
  - Zero.
- Reset mid-operation discards in-flight results; no Out_valid pulse follows.
- Operand select: X = Acc ? acc : A.
- Op encoding, R = f(X,B):
  - 000 AND; 001 OR; 010 XOR; 011 NAND; 100 NOR; 101 XNOR;
  - 110 pass X; 111 NOT X.
- Op=000 and 001 with WIDTH=1 reproduce the legacy AND/OR cell.
- Accept: a cycle with CE=1 and In_valid=1.
- On accept:
  - stage 1 data <= R and stage 1 valid <= 1;
  - acc <= R, in both Acc modes, so accumulation continues from the last accepted result.
- CE=1, In_valid=0:
  - stage 1 valid <= 0;
  - stage 1 data is don't-care, and the implementation holds it;
  - acc unchanged.
- Pipeline (CE=1): stage k <= stage k-1 for k=2..STAGES. Q and Out_valid are stage STAGES.
- Latency: result of an accept appears on Q with Out_valid=1 exactly STAGES enabled edges after the accept edge.
- CE=0 stall:
  - no register changes, including acc, Q and Out_valid;
  - latency counts enabled edges only.
- Back-to-back accepts: one result per enabled cycle; no bubbles inserted.
- Out_valid=0: Q retains its last stage data. The bench checks Q only when Out_valid=1.
- Acc=1 with In_valid=0: no effect; A is ignored whenever Acc=1.
- Width rule:
  - all operations are bitwise, with no carries;
  - the result is exactly WIDTH bits;
  - no sign extension or truncation arises.
- Simultaneous Clr and accept: Clr wins; acc=0 afterwards and nothing is accepted.

Optional Feature:
- Macro: LOGIC_ZERO_FLAG_EN.
- Defined:
  - output Zero is present;
  - Zero is registered alongside Q and equals 1 when Out_valid=1 and Q==0, else 0;
  - it has the same latency and stall behaviour as Q;
  - Clr drives it to 0.
- Undefined: the Zero port and its logic are absent; all other behaviour is identical.

Test Plan (WIDTH=8 unless stated):
1. STAGES=1, Clr=1 one edge, then CE=1, In_valid=1, Acc=0, A=0xF0, B=0x3C, Op=000 -> one edge later Q=0x30, Out_valid=1. Op=001 next cycle -> Q=0x3C|0xF0=0xFC.
2. STAGES=2, A=0xAA, B=0x0F, Op cycling 010,011,100,101,110,111 back-to-back -> Q sequence 0xA5,0xF5,0x50,0x5A,0xAA,0x55 starting 2 enabled edges after the first accept, Out_valid high continuously.
3. Accumulate: accept A=0x01,B=0x00,Op=001,Acc=0; then Acc=1, Op=001, B=0x02, 0x04, 0x08 -> Q = 0x01,0x03,0x07,0x0F.
4. Stall: STAGES=3, accept 0x11 (Op=110), then CE=0 for 5 cycles -> Q and Out_valid frozen throughout. The result appears after the 3rd enabled edge overall, not earlier.
5. Reset mid-flight: STAGES=3, two accepts, Clr=1 on the next edge with CE=0 -> Q=0, Out_valid=0, no valid output ever appears for the flushed data. The next accept with Acc=1, B=0x5A, Op=001 yields 0x5A, confirming acc=0.
6. With LOGIC_ZERO_FLAG_EN, STAGES=1: A=0x0F, B=0xF0, Op=000 -> Q=0x00, Zero=1. Op=001 -> Q=0xFF, Zero=0. With In_valid=0 -> Zero=0 once Out_valid=0.
